output_drain_scheduler: RTL

Sequencer for the dual-port output bridge of the 5x5 overlay. It watches the valid flags of the 20 output FIFOs and grants host read slots on port 0 and port 1, producing the bridge's `port0/port1/rd_en0/rd_en1` controls. Grants are round-robin among the FIFOs mapped to each port and respect host backpressure. The block also tracks end-of-stream (`done0/done1`) per FIFO and raises `all_done` when every mapped stream has finished.

---
 rtl/output_drain_scheduler.sv | 138 +++++++++++++
 1 files changed

// File: rtl/output_drain_scheduler.sv
// Round-robin read-slot sequencer for the dual-port output bridge: grants one
// FIFO per port per cycle, tracks end-of-stream per FIFO and counts delivered words.
module output_drain_scheduler #(
   parameter int unsigned NUM_FIFOS = 20,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 conf_en,
   input  logic                 cfg_we,
   input  logic [4:0]           cfg_idx,
   input  logic [1:0]           cfg_sel,
   input  logic [NUM_FIFOS-1:0] fifo_valid,
   input  logic                 ready0,
   input  logic                 ready1,
   input  logic                 done0,
   input  logic                 done1,
   output logic [4:0]           port0,
   output logic [4:0]           port1,
   output logic                 rd_en0,
   output logic                 rd_en1,
   output logic                 all_done,
   output logic [CNT_WIDTH-1:0] words0,
   output logic [CNT_WIDTH-1:0] words1
);

   localparam int unsigned IDX_W = 5;
   localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_FIFOS - 1);

   logic [NUM_FIFOS-1:0] r_map0, r_map1, r_done_seen;
   logic [IDX_W-1:0]     r_last0, r_last1, r_port0, r_port1;
   logic                 r_rd_en0, r_rd_en1, r_all_done, r_conf_q;
   logic [CNT_WIDTH-1:0] r_words0, r_words1;

   logic [NUM_FIFOS-1:0] w_map0_n, w_map1_n, w_done_n, w_elig0, w_elig1, w_mapped;
   logic [IDX_W:0]       w_pick0, w_pick1;
   logic                 w_grant0, w_grant1, w_rise, w_all_done_n;

   // First eligible index strictly after 'last', wrapping; MSB flags a winner.
   function automatic logic [IDX_W:0] f_pick(input logic [NUM_FIFOS-1:0] elig,
                                             input logic [IDX_W-1:0] last);
      logic             found;
      logic [IDX_W-1:0] win;
      int unsigned      idx;
      found = 1'b0;
      win   = '0;
      for (int unsigned off = 1; off <= NUM_FIFOS; off++) begin
         idx = 32'(last) + off;
         if (idx >= NUM_FIFOS) idx = idx - NUM_FIFOS;
         if (!found && elig[IDX_W'(idx)]) begin
            found = 1'b1;
            win   = IDX_W'(idx);
         end
      end
      return {found, win};
   endfunction

   always_comb begin
      w_map0_n = r_map0;
      w_map1_n = r_map1;
      if (conf_en && cfg_we && (cfg_idx < IDX_W'(NUM_FIFOS))) begin
         w_map0_n[cfg_idx] = (cfg_sel == 2'b01);
         w_map1_n[cfg_idx] = (cfg_sel == 2'b10);
      end
   end

   // The FIFO just read still shows its pre-dequeue valid this cycle, so mask it.
   always_comb begin
      w_elig0 = r_map0 & fifo_valid & ~r_done_seen;
      w_elig1 = r_map1 & fifo_valid & ~r_done_seen;
      if (r_rd_en0) w_elig0[r_port0] = 1'b0;
      if (r_rd_en1) w_elig1[r_port1] = 1'b0;
      w_pick0  = f_pick(w_elig0, r_last0);
      w_pick1  = f_pick(w_elig1, r_last1);
      w_grant0 = ready0 && !conf_en && w_pick0[IDX_W];
      w_grant1 = ready1 && !conf_en && w_pick1[IDX_W];
   end

   always_comb begin
      w_done_n = r_done_seen;
      if (r_rd_en0 && done0) w_done_n[r_port0] = 1'b1;
      if (r_rd_en1 && done1) w_done_n[r_port1] = 1'b1;
      w_mapped     = r_map0 | r_map1;
      w_all_done_n = (w_mapped != '0) && ((w_mapped & ~r_done_seen) == '0);
      w_rise       = conf_en && !r_conf_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_map0      <= '0;
         r_map1      <= '0;
         r_done_seen <= '0;
         r_last0     <= LAST_INIT;
         r_last1     <= LAST_INIT;
         r_port0     <= '0;
         r_port1     <= '0;
         r_rd_en0    <= 1'b0;
         r_rd_en1    <= 1'b0;
         r_all_done  <= 1'b0;
         r_conf_q    <= 1'b0;
         r_words0    <= '0;
         r_words1    <= '0;
      end else begin
         r_conf_q <= conf_en;
         r_map0   <= w_map0_n;
         r_map1   <= w_map1_n;
         r_rd_en0 <= w_grant0;
         r_rd_en1 <= w_grant1;
         if (w_grant0) r_port0 <= w_pick0[IDX_W-1:0];
         if (w_grant1) r_port1 <= w_pick1[IDX_W-1:0];
         // A new configuration phase restarts each search at FIFO 0.
         if (w_rise) begin
            r_last0     <= LAST_INIT;
            r_last1     <= LAST_INIT;
            r_done_seen <= '0;
            r_all_done  <= 1'b0;
            r_words0    <= '0;
            r_words1    <= '0;
         end else begin
            if (w_grant0) r_last0 <= w_pick0[IDX_W-1:0];
            if (w_grant1) r_last1 <= w_pick1[IDX_W-1:0];
            r_done_seen <= w_done_n;
            r_all_done  <= w_all_done_n;
            if (r_rd_en0 && (r_words0 != '1)) r_words0 <= r_words0 + CNT_WIDTH'(1);
            if (r_rd_en1 && (r_words1 != '1)) r_words1 <= r_words1 + CNT_WIDTH'(1);
         end
      end
   end

   assign port0    = r_port0;
   assign port1    = r_port1;
   assign rd_en0   = r_rd_en0;
   assign rd_en1   = r_rd_en1;
   assign all_done = r_all_done;
   assign words0   = r_words0;
   assign words1   = r_words1;

endmodule
